ahb_apb4_bridge: RTL and testbench
==================================

// Module: ahb_apb4_bridge
// PURPOSE
//  AHB-Lite slave to APB4 master bridge with N parametrised slaves.
//  Decodes slaves by base/size window and generates PSTRB from HSIZE. Adds wait states via HREADYOUT.
//  Maps PSLVERR, unmapped addresses, illegal sizes and APB timeouts to a two-cycle AHB ERROR response.
//  Sits between the AHB interconnect and the peripheral APB segment.
// PARAMETERS
//  NO_OF_SLAVES     8      number of APB slaves (1..32)
//  ADDR_WIDTH       32     HADDR/PADDR width
//  DATA_WIDTH       32     data width (32 or 64)
//  SLAVE_BASE       'h0    byte address of slave 0 window
//  SLAVE_SIZE_LOG2  8      log2 window bytes; slave i = [BASE+i<<SIZE, BASE+(i+1)<<SIZE-1]
//  TIMEOUT_CYCLES   16     max ACCESS cycles without PREADY before ERROR; 0 disables
// PORTS
//  HCLK       in   1                 clock, all logic on posedge
//  HRESETn    in   1                 asynchronous active-low reset
//  HSEL       in   1                 bridge select
//  HADDR      in   ADDR_WIDTH        AHB address
//  HTRANS     in   2                 AHB transfer type
//  HWRITE     in   1                 1=write
//  HSIZE      in   3                 transfer size
//  HWDATA     in   DATA_WIDTH        write data (data phase)
//  HREADYIN   in   1                 bus-level HREADY
//  HRDATA     out  DATA_WIDTH        read data
//  HREADYOUT  out  1                 bridge ready
//  HRESP      out  1                 0=OKAY 1=ERROR
//  PSELx      out  NO_OF_SLAVES      one-hot slave select
//  PENABLE    out  1                 APB access phase
//  PADDR      out  ADDR_WIDTH        APB address (full HADDR)
//  PWRITE     out  1                 APB direction
//  PWDATA     out  DATA_WIDTH        APB write data
//  PSTRB      out  DATA_WIDTH/8      byte strobes, all 0 on reads
//  PRDATA     in   NO_OF_SLAVES*DATA_WIDTH  slave i at [i*DW +: DW]
//  PREADY     in   NO_OF_SLAVES      per-slave ready
//  PSLVERR    in   NO_OF_SLAVES      per-slave error, valid with PREADY
// BEHAVIOUR
//  Reset: all outputs 0 except HREADYOUT=1; state IDLE, timeout counter 0. Applies mid-transfer: PSELx/PENABLE drop at once.
//  Accept: HSEL & HREADYIN & HTRANS[1] & HREADYOUT. Register HADDR/HWRITE/HSIZE and slave index.
//  IDLE/BUSY transfers get zero-wait OKAY.
//  Decode: idx=(HADDR-SLAVE_BASE)>>SLAVE_SIZE_LOG2. Unmapped if HADDR<SLAVE_BASE or idx>=NO_OF_SLAVES.
//  Illegal: 8<<HSIZE > DATA_WIDTH, or HADDR not aligned to size. Unmapped or illegal -> ERR1, no PSEL.
//  PSTRB: ((1<<(1<<HSIZE))-1) << HADDR[log2(DW/8)-1:0]; 0 on reads.
//  FSM (one registered state):
//   IDLE:   HREADYOUT=1. Accept read -> SETUP; write -> WLATCH; bad -> ERR1.
//   WLATCH: HREADYOUT=0. PWDATA<=HWDATA. -> SETUP.
//   SETUP:  PSELx[idx]=1, PENABLE=0, PADDR/PWRITE/PSTRB valid. -> ACCESS.
//   ACCESS: PENABLE=1, timer counts. Stays in ACCESS while PREADY[idx]=0.
//     PREADY[idx]=1 & !PSLVERR -> RESP; HRDATA<=PRDATA slice on reads.
//     PREADY[idx]=1 & PSLVERR -> ERR1.
//     Timer reaches TIMEOUT_CYCLES -> ERR1; PSELx/PENABLE deassert.
//   RESP:   HREADYOUT=1, HRESP=0. Accepts next transfer like IDLE (back-to-back); else -> IDLE.
//   ERR1:   HREADYOUT=0, HRESP=1, PSELx=0, PENABLE=0. -> ERR2.
//   ERR2:   HREADYOUT=1, HRESP=1. Accepts next transfer like IDLE.
//  Latency, zero-wait slave: read data phase 3 cycles (HREADYOUT low 2); write 4 cycles (low 3). Each APB wait adds 1.
//  PADDR/PWRITE/PSTRB/PWDATA hold from SETUP until the cycle after completion.
//  PSELx never multi-hot. PENABLE only asserted in the cycle after SETUP.
//  HRDATA holds last read value until the next read completes.
//  PREADY/PSLVERR of non-selected slaves are ignored.
//  Timer clears on every SETUP entry; it never wraps.
// TESTING
//  Read 0x104, slave1 PREADY=1 PRDATA=0xA5A5_0001 -> PSELx=8'h02 one cycle SETUP then ACCESS; 3-cycle data phase; HRDATA=0xA5A5_0001 OKAY.
//  Byte write 0x302 HSIZE=0 HWDATA=0x00CC_0000 -> PSELx=8'h08, PSTRB=4'b0100, PWDATA=0x00CC_0000, PWRITE=1; 4-cycle data phase.
//  Slave2 PREADY low 3 cycles then PREADY=1 PSLVERR=1 -> ACCESS held 4 cycles; ERR1 (HREADYOUT=0,HRESP=1) then ERR2 (1,1).
//  Access 0x900 (unmapped) and word access at 0x101 -> no PSELx activity; two-cycle ERROR each.
//  Slave0 PREADY stuck 0, TIMEOUT_CYCLES=16 -> PENABLE high 16 cycles, then ERROR; next read to slave1 completes OKAY.
//  Back-to-back write 0x000 then read 0x204; HRESETn low during second ACCESS -> PSELx=0 and HREADYOUT=1 immediately.

Source files
------------

// File: rtl/ahb_apb4_bridge.sv
// AHB-Lite slave to APB4 master bridge decoding N slaves by base/size window.
// Bad address/size, PSLVERR and APB timeout all return a two-cycle AHB ERROR.
module ahb_apb4_bridge #(
  parameter int unsigned           NO_OF_SLAVES    = 8,
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter int unsigned           DATA_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] SLAVE_BASE      = '0,
  parameter int unsigned           SLAVE_SIZE_LOG2 = 8,
  parameter int unsigned           TIMEOUT_CYCLES  = 16
) (
  input  logic                               HCLK,
  input  logic                               HRESETn,
  input  logic                               HSEL,
  input  logic [ADDR_WIDTH-1:0]              HADDR,
  input  logic [1:0]                         HTRANS,
  input  logic                               HWRITE,
  input  logic [2:0]                         HSIZE,
  input  logic [DATA_WIDTH-1:0]              HWDATA,
  input  logic                               HREADYIN,
  output logic [DATA_WIDTH-1:0]              HRDATA,
  output logic                               HREADYOUT,
  output logic                               HRESP,
  output logic [NO_OF_SLAVES-1:0]            PSELx,
  output logic                               PENABLE,
  output logic [ADDR_WIDTH-1:0]              PADDR,
  output logic                               PWRITE,
  output logic [DATA_WIDTH-1:0]              PWDATA,
  output logic [DATA_WIDTH/8-1:0]            PSTRB,
  input  logic [NO_OF_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NO_OF_SLAVES-1:0]            PREADY,
  input  logic [NO_OF_SLAVES-1:0]            PSLVERR
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned LaneW = $clog2(StrbW);
  localparam int unsigned IdxW  = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;
  localparam int unsigned TmrW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWlatch = 3'd1;
  localparam logic [2:0] StSetup  = 3'd2;
  localparam logic [2:0] StAccess = 3'd3;
  localparam logic [2:0] StResp   = 3'd4;
  localparam logic [2:0] StErr1   = 3'd5;
  localparam logic [2:0] StErr2   = 3'd6;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [StrbW-1:0]      strb_q;
  logic [IdxW-1:0]       idx_q;
  logic [DATA_WIDTH-1:0] pwdata_q, hrdata_q;
  logic [TmrW-1:0]       timer_q;

  logic [ADDR_WIDTH-1:0] offset, slot;
  logic [2:0]            align_mask;
  logic [StrbW-1:0]      strb;
  logic                  unmapped, illegal, accept;
  logic                  sel_ready, sel_err, timeout;
  logic [DATA_WIDTH-1:0] sel_rdata;
  int                    lane, nbytes;

  logic unused_htrans;
  assign unused_htrans = HTRANS[0];

  always_comb begin
    offset     = HADDR - SLAVE_BASE;
    slot       = offset >> SLAVE_SIZE_LOG2;
    unmapped   = (HADDR < SLAVE_BASE) || (slot >= ADDR_WIDTH'(NO_OF_SLAVES));
    align_mask = (3'b001 << HSIZE) - 3'b001;
    illegal    = (int'(HSIZE) > int'(LaneW)) || ((HADDR[2:0] & align_mask) != 3'b000);
    lane       = int'(HADDR[LaneW-1:0]);
    nbytes     = 1 << HSIZE;
    strb       = '0;
    for (int b = 0; b < int'(StrbW); b++) begin
      strb[b] = HWRITE && (b >= lane) && (b < lane + nbytes);
    end
  end

  assign HREADYOUT = (state_q == StIdle) || (state_q == StResp) || (state_q == StErr2);
  assign HRESP     = (state_q == StErr1) || (state_q == StErr2);
  assign accept    = HSEL && HREADYIN && HTRANS[1] && HREADYOUT;

  assign sel_ready = PREADY[idx_q];
  assign sel_err   = PSLVERR[idx_q];
  assign sel_rdata = PRDATA[idx_q*DATA_WIDTH +: DATA_WIDTH];
  assign timeout   = (TIMEOUT_CYCLES != 0) && (timer_q == TmrW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StResp, StErr2: begin
        if (!accept)                  state_d = StIdle;
        else if (unmapped || illegal) state_d = StErr1;
        else if (HWRITE)              state_d = StWlatch;
        else                          state_d = StSetup;
      end
      StWlatch: state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: begin
        // A completing PREADY wins over a timeout landing in the same cycle
        if (sel_ready)    state_d = sel_err ? StErr1 : StResp;
        else if (timeout) state_d = StErr1;
      end
      StErr1:   state_d = StErr2;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      write_q  <= 1'b0;
      strb_q   <= '0;
      idx_q    <= '0;
      pwdata_q <= '0;
      hrdata_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= HADDR;
        write_q <= HWRITE;
        strb_q  <= strb;
        idx_q   <= slot[IdxW-1:0];
      end
      if (state_q == StWlatch) pwdata_q <= HWDATA;
      if (state_d == StSetup) begin
        timer_q <= '0;
      end else if ((state_q == StAccess) && (timer_q != '1)) begin
        timer_q <= timer_q + TmrW'(1);
      end
      if ((state_q == StAccess) && sel_ready && !sel_err && !write_q) hrdata_q <= sel_rdata;
    end
  end

  always_comb begin
    PSELx = '0;
    if ((state_q == StSetup) || (state_q == StAccess)) PSELx[idx_q] = 1'b1;
  end

  assign PENABLE = (state_q == StAccess);
  assign PADDR   = addr_q;
  assign PWRITE  = write_q;
  assign PSTRB   = strb_q;
  assign PWDATA  = pwdata_q;
  assign HRDATA  = hrdata_q;

endmodule

// File: tb/tb_ahb_apb4_bridge.sv
// Bench for ahb_apb4_bridge: directed scenarios plus random transfers against a
// word-memory reference of eight 256-byte APB slaves.
module tb_ahb_apb4_bridge;

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic         HSEL;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic         HWRITE;
  logic [2:0]   HSIZE;
  logic [31:0]  HWDATA;
  logic         HREADYIN;
  logic [31:0]  HRDATA;
  logic         HREADYOUT;
  logic         HRESP;
  logic [7:0]   PSELx;
  logic         PENABLE;
  logic [31:0]  PADDR;
  logic         PWRITE;
  logic [31:0]  PWDATA;
  logic [3:0]   PSTRB;
  logic [255:0] PRDATA;
  logic [7:0]   PREADY;
  logic [7:0]   PSLVERR;

  ahb_apb4_bridge dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADYIN  (HREADYIN),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .PSELx     (PSELx),
    .PENABLE   (PENABLE),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem   [8][64];
  logic [31:0] slave_mem [8][64];
  logic [31:0] hrdata_exp;
  bit          mem_ready = 1'b0;

  function automatic logic [31:0] init_word(input int i, input int w);
    return 32'h5A00_0000 ^ (32'(i) << 16) ^ (32'(w) * 32'h0000_0301);
  endfunction

  // APB slaves: word memories indexed by PADDR[7:2], written under PSTRB on completion
  always @(posedge HCLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 8; i++)
        for (int w = 0; w < 64; w++) slave_mem[i][w] <= init_word(i, w);
      mem_ready <= 1'b1;
    end else begin
      for (int i = 0; i < 8; i++)
        if (PSELx[i] && PENABLE && PWRITE && PREADY[i] && !PSLVERR[i])
          for (int b = 0; b < 4; b++)
            if (PSTRB[b]) slave_mem[i][PADDR[7:2]][8*b +: 8] <= PWDATA[8*b +: 8];
    end
  end

  always_comb begin
    PRDATA = '0;
    for (int i = 0; i < 8; i++) PRDATA[i*32 +: 32] = slave_mem[i][PADDR[7:2]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // Non-selected slaves get random handshakes; the DUT must ignore them
  task automatic drive_slaves(input int idx, input bit rdy, input bit err);
    PREADY  = 8'($urandom);
    PSLVERR = 8'($urandom);
    if (idx >= 0) begin
      PREADY[idx]  = rdy;
      PSLVERR[idx] = err;
    end
  endtask

  task automatic idle(input int n);
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    for (int i = 0; i < n; i++) begin
      drive_slaves(-1, 1'b0, 1'b0);
      step();
    end
  endtask

  // Full AHB transfer; returns in the final data-phase cycle (HREADYOUT high)
  task automatic xfer(input logic [31:0] addr, input bit wr, input logic [2:0] size,
                      input logic [31:0] wdata, input int waits, input bit slverr);
    int         idx, nacc, word;
    bit         bad, fail;
    logic [3:0] strb_e;
    idx    = int'(addr >> 8);
    word   = int'(addr[7:2]);
    bad    = (idx >= 8) || (size > 3'd2) || ((addr % (32'd1 << size)) != 0);
    strb_e = wr ? 4'(((1 << (1 << size)) - 1) << (addr % 4)) : 4'b0000;
    nacc   = (waits >= 16) ? 16 : waits + 1;
    fail   = (waits >= 16) || slverr;

    chk("addr_phase_ready", 64'(HREADYOUT), 64'(1));
    HSEL = 1'b1; HADDR = addr; HTRANS = 2'b10; HWRITE = wr; HSIZE = size; HREADYIN = 1'b1;
    drive_slaves(-1, 1'b0, 1'b0);
    step();
    HSEL = 1'b0; HTRANS = 2'b00; HADDR = $urandom; HWDATA = wdata;

    if (bad) begin
      chk("bad_err1", 64'({HREADYOUT, HRESP, PSELx, PENABLE}), 64'({2'b01, 8'h00, 1'b0}));
      step();
      chk("bad_err2", 64'({HREADYOUT, HRESP, PSELx, PENABLE}), 64'({2'b11, 8'h00, 1'b0}));
      chk("bad_hrdata", 64'(HRDATA), 64'(hrdata_exp));
      return;
    end

    if (wr) begin
      chk("wlatch", 64'({HREADYOUT, HRESP, PSELx, PENABLE}), 64'({2'b00, 8'h00, 1'b0}));
      step();
      HWDATA = $urandom;
    end

    chk("setup_ctl", 64'({HREADYOUT, PSELx, PENABLE, PWRITE, PSTRB}),
        64'({1'b0, 8'(1 << idx), 1'b0, wr, strb_e}));
    chk("setup_paddr", 64'(PADDR), 64'(addr));
    if (wr) chk("setup_pwdata", 64'(PWDATA), 64'(wdata));
    step();

    for (int k = 0; k < nacc; k++) begin
      chk("access", 64'({HREADYOUT, PSELx, PENABLE, PADDR}),
          64'({1'b0, 8'(1 << idx), 1'b1, addr}));
      if (k == waits) drive_slaves(idx, 1'b1, slverr);
      else            drive_slaves(idx, 1'b0, 1'($urandom));
      step();
    end
    drive_slaves(-1, 1'b0, 1'b0);

    if (fail) begin
      chk("apb_err1", 64'({HREADYOUT, HRESP, PSELx, PENABLE}), 64'({2'b01, 8'h00, 1'b0}));
      step();
      chk("apb_err2", 64'({HREADYOUT, HRESP}), 64'(2'b11));
    end else begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (strb_e[b]) ref_mem[idx][word][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        hrdata_exp = ref_mem[idx][word];
      end
      chk("resp", 64'({HREADYOUT, HRESP, PSELx, PENABLE}), 64'({2'b10, 8'h00, 1'b0}));
      chk("resp_hold", 64'({PADDR, PWRITE, PSTRB}), 64'({addr, wr, strb_e}));
    end
    chk(fail ? "err_hrdata" : "resp_hrdata", 64'(HRDATA), 64'(hrdata_exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          s, sz, wt;
  bit          wr_r, er_r;
  logic [31:0] a, off;

  initial begin
    for (int i = 0; i < 8; i++)
      for (int w = 0; w < 64; w++) ref_mem[i][w] = init_word(i, w);
    hrdata_exp = '0;
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'd0; HWDATA = '0; HREADYIN = 1'b1;
    drive_slaves(-1, 1'b0, 1'b0);
    step(); step(); step();
    chk("reset_ahb", 64'({HREADYOUT, HRESP, HRDATA}), 64'({2'b10, 32'h0}));
    chk("reset_apb", 64'({PSELx, PENABLE, PWRITE, PSTRB, PADDR}), 64'(0));
    chk("reset_pwdata", 64'(PWDATA), 64'(0));
    HRESETn = 1'b1;
    idle(2);
    chk("idle_after_reset", 64'({HREADYOUT, HRESP, PSELx}), 64'({2'b10, 8'h00}));

    // Word write then read on slave 1
    xfer(32'h0000_0104, 1'b1, 3'd2, 32'hA5A5_0001, 0, 1'b0);
    idle(1);
    xfer(32'h0000_0104, 1'b0, 3'd2, 32'h0, 0, 1'b0);
    chk("read_0x104", 64'(HRDATA), 64'(32'hA5A5_0001));
    idle(1);
    // Byte write to lane 2 of slave 3
    xfer(32'h0000_0302, 1'b1, 3'd0, 32'h00CC_0000, 0, 1'b0);
    idle(1);
    // Slave 2: three waits then PSLVERR
    xfer(32'h0000_0208, 1'b0, 3'd2, 32'h0, 3, 1'b1);
    idle(1);
    // Unmapped and misaligned
    xfer(32'h0000_0900, 1'b0, 3'd2, 32'h0, 0, 1'b0);
    xfer(32'h0000_0101, 1'b0, 3'd2, 32'h0, 0, 1'b0);
    idle(1);
    // Timeout on slave 0, then a clean read to slave 1
    xfer(32'h0000_0000, 1'b0, 3'd2, 32'h0, 20, 1'b0);
    xfer(32'h0000_0104, 1'b0, 3'd2, 32'h0, 0, 1'b0);
    idle(1);

    for (int t = 0; t < 60; t++) begin
      s    = int'($urandom_range(0, 8));
      sz   = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      off  = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) != 0) off = off & ~((32'd1 << sz) - 32'd1);
      a    = (32'(s) << 8) | (32'($urandom_range(0, 3)) << 2) | off;
      wr_r = 1'($urandom);
      er_r = ($urandom_range(0, 7) == 0);
      wt   = ($urandom_range(0, 19) == 0) ? 17 : int'($urandom_range(0, 3));
      xfer(a, wr_r, 3'(sz), $urandom, wt, er_r);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
    end
    idle(1);

    // Back-to-back write then read, reset asserted during the read's ACCESS
    xfer(32'h0000_0000, 1'b1, 3'd2, $urandom, 0, 1'b0);
    HSEL = 1'b1; HADDR = 32'h0000_0204; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'd2;
    step();
    HSEL = 1'b0; HTRANS = 2'b00;
    chk("b2b_setup", 64'({HREADYOUT, PSELx, PENABLE}), 64'({1'b0, 8'h04, 1'b0}));
    drive_slaves(2, 1'b0, 1'b0);
    step();
    chk("b2b_access", 64'({HREADYOUT, PSELx, PENABLE}), 64'({1'b0, 8'h04, 1'b1}));
    #2;
    HRESETn = 1'b0;
    #1;
    chk("midreset_apb", 64'({PSELx, PENABLE, PADDR}), 64'(0));
    chk("midreset_ahb", 64'({HREADYOUT, HRESP, HRDATA}), 64'({2'b10, 32'h0}));
    hrdata_exp = '0;
    step();
    HRESETn = 1'b1;
    idle(2);
    xfer(32'h0000_0204, 1'b0, 3'd2, 32'h0, 1, 1'b0);
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
